// File: rtl/vdp99_cpu_port_if.sv
// VRAM request/acknowledge bus between the VDP99 CPU port and the VRAM arbiter.
// The CPU port is the master (raises requests); the arbiter is the slave.
interface vdp99_cpu_port_if #(
  parameter int ADDR_WIDTH = 14
);
  logic [ADDR_WIDTH-1:0] vram_addr;
  logic [7:0]            vram_wdata;
  logic                  vram_we;
  logic                  vram_req;
  logic                  vram_ack;
  logic [7:0]            vram_rdata;

  modport master (
    output vram_addr, vram_wdata, vram_we, vram_req,
    input  vram_ack, vram_rdata
  );

  modport slave (
    input  vram_addr, vram_wdata, vram_we, vram_req,
    output vram_ack, vram_rdata
  );
endinterface

// File: rtl/vdp99_cpu_port.sv
// VDP99 CPU-side front end: decodes Z80 data/control port strobes into register
// writes, VRAM address set-up, VRAM read/write requests and status reads.
// Optional feature macro: VDP99_CPU_WAIT_EN adds a cpu_wait stall output so a
// data read always returns read-ahead data fetched after any in-flight request.
module vdp99_cpu_port #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [63:0] REG_RESET  = 64'h0
) (
  input  logic        phi,
  input  logic        reset,
  input  logic        cpu_mode,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [63:0] vdp_regs,
  input  logic        frame_tick,
  input  logic        spr_coll,
  input  logic        spr_5s,
  input  logic [4:0]  spr_5th_num,
  output logic        irq,
`ifdef VDP99_CPU_WAIT_EN
  output logic        cpu_wait,
`endif
  vdp99_cpu_port_if.master vram
);

  typedef enum logic {V_IDLE, V_BUSY} vstate_t;

  vstate_t               state, state_nx;
  logic [7:0][7:0]       regs;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            latch, read_buf;
  logic                  flag;
  logic                  st_f, st_5s, st_c;
  logic [4:0]            st_num;
  logic                  wr_q, rd_q, rd_mode;

  logic [ADDR_WIDTH-1:0] req_addr, pend_addr, new_addr;
  logic [7:0]            req_wdata, pend_wdata, new_wdata;
  logic                  req_we, pend_we, new_we, pend_valid, new_req;
  logic                  issue_new, issue_pend, to_pend, vram_done;

  logic                  rd_now, rd_edge, rd_rel, wr_edge;
  logic                  ctrl_wr, data_wr, data_rel, stat_rel;
  logic                  load_data, load_stat;
  logic [13:0]           setup_full;
  logic [ADDR_WIDTH-1:0] setup_addr;

  // A write strobe masks a simultaneous read strobe entirely.
  assign rd_now   = cpu_rd & ~cpu_wr;
  assign rd_edge  = rd_now & ~rd_q;
  assign rd_rel   = ~rd_now & rd_q;
  assign wr_edge  = cpu_wr & ~wr_q;
  assign ctrl_wr  = wr_edge & cpu_mode;
  assign data_wr  = wr_edge & ~cpu_mode;
  assign data_rel = rd_rel & ~rd_mode;
  assign stat_rel = rd_rel & rd_mode;
  assign load_stat = rd_edge & cpu_mode;

  assign setup_full = {cpu_din[5:0], latch};
  assign setup_addr = ADDR_WIDTH'(setup_full);

`ifdef VDP99_CPU_WAIT_EN
  logic wait_q;
  assign cpu_wait  = cpu_rd & ~cpu_mode & (vram.vram_req | pend_valid);
  // Load is deferred until the stall lifts so read_buf holds the newest fetch.
  assign load_data = rd_now & ~cpu_mode & ~cpu_wait & (rd_edge | wait_q);
`else
  assign load_data = rd_edge & ~cpu_mode;
`endif

  assign vdp_regs        = regs;
  assign irq             = st_f & regs[1][5];
  assign vram.vram_req   = (state == V_BUSY);
  assign vram.vram_addr  = req_addr;
  assign vram.vram_wdata = req_wdata;
  assign vram.vram_we    = req_we;
  assign vram_done       = (state == V_BUSY) & vram.vram_ack;

  // Decode the VRAM transaction (if any) raised by this cycle's CPU access.
  always_comb begin
    new_req   = 1'b0;
    new_addr  = addr;
    new_wdata = cpu_din;
    new_we    = 1'b0;
    if (data_wr) begin
      new_req = 1'b1;
      new_we  = 1'b1;
    end else if (ctrl_wr && flag && cpu_din[7:6] == 2'b00) begin
      new_req  = 1'b1;
      new_addr = setup_addr;
    end else if (data_rel) begin
      new_req = 1'b1;
    end
  end

  // Request FSM: a pending entry takes the slot at ack, ahead of a coincident new request.
  always_comb begin
    state_nx   = state;
    issue_new  = 1'b0;
    issue_pend = 1'b0;
    to_pend    = 1'b0;
    case (state)
      V_IDLE: begin
        if (new_req) begin
          issue_new = 1'b1;
          state_nx  = V_BUSY;
        end
      end
      V_BUSY: begin
        if (vram.vram_ack) begin
          if (pend_valid) begin
            issue_pend = 1'b1;
            to_pend    = new_req;
          end else if (new_req) begin
            issue_new = 1'b1;
          end else begin
            state_nx = V_IDLE;
          end
        end else begin
          to_pend = new_req;
        end
      end
      default: state_nx = V_IDLE;
    endcase
  end

  // Request FSM state register.
  always_ff @(posedge phi) begin
    if (reset) state <= V_IDLE;
    else       state <= state_nx;
  end

  // Outstanding request and one-deep pending slot.
  always_ff @(posedge phi) begin
    if (reset) begin
      req_addr   <= '0;
      req_wdata  <= '0;
      req_we     <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      pend_we    <= 1'b0;
      pend_valid <= 1'b0;
    end else begin
      if (issue_pend) begin
        req_addr  <= pend_addr;
        req_wdata <= pend_wdata;
        req_we    <= pend_we;
      end else if (issue_new) begin
        req_addr  <= new_addr;
        req_wdata <= new_wdata;
        req_we    <= new_we;
      end
      if (to_pend) begin
        pend_valid <= 1'b1;
        pend_addr  <= new_addr;
        pend_wdata <= new_wdata;
        pend_we    <= new_we;
      end else if (issue_pend) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // CPU-visible state: strobes, registers, address, buffers and status flags.
  always_ff @(posedge phi) begin
    if (reset) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      rd_mode  <= 1'b0;
      regs     <= REG_RESET;
      addr     <= '0;
      latch    <= '0;
      flag     <= 1'b0;
      read_buf <= '0;
      cpu_dout <= '0;
      st_f     <= 1'b0;
      st_5s    <= 1'b0;
      st_c     <= 1'b0;
      st_num   <= '0;
`ifdef VDP99_CPU_WAIT_EN
      wait_q   <= 1'b0;
`endif
    end else begin
      wr_q <= cpu_wr;
      rd_q <= rd_now;
      if (rd_edge) rd_mode <= cpu_mode;
`ifdef VDP99_CPU_WAIT_EN
      wait_q <= cpu_wait;
`endif
      if (ctrl_wr) begin
        if (!flag) begin
          latch <= cpu_din;
          flag  <= 1'b1;
        end else begin
          flag <= 1'b0;
          if (cpu_din[7])      regs[cpu_din[2:0]] <= latch;
          else if (cpu_din[6]) addr <= setup_addr;
          else                 addr <= setup_addr + ADDR_WIDTH'(1);
        end
      end else if (data_wr || data_rel) begin
        addr <= addr + ADDR_WIDTH'(1);
        flag <= 1'b0;
      end else if (stat_rel) begin
        flag <= 1'b0;
      end
      if (vram_done && !req_we) read_buf <= vram.vram_rdata;
      if (data_wr)              read_buf <= cpu_din;
      if (load_data)      cpu_dout <= read_buf;
      else if (load_stat) cpu_dout <= {st_f, st_5s, st_c, st_num};
      // Set pulses override the clear-on-status-read.
      st_f  <= (st_f  & ~stat_rel) | frame_tick;
      st_5s <= (st_5s & ~stat_rel) | spr_5s;
      st_c  <= (st_c  & ~stat_rel) | spr_coll;
      if (spr_5s) st_num <= spr_5th_num;
    end
  end

endmodule

// File: tb/tb_vdp99_cpu_port.sv
// Self-checking bench for vdp99_cpu_port: transaction-level model of the CPU
// port plus a VRAM responder that checks each request against model order.
module tb_vdp99_cpu_port;
  localparam logic [63:0] RST_REGS = 64'hC300_0000_0000_00F0;

  logic        phi = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_mode = 1'b0, cpu_wr = 1'b0, cpu_rd = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic [63:0] vdp_regs;
  logic        frame_tick = 1'b0, spr_coll = 1'b0, spr_5s = 1'b0;
  logic [4:0]  spr_5th_num = '0;
  logic        irq;

  vdp99_cpu_port_if #(.ADDR_WIDTH(14)) vram_bus ();

  vdp99_cpu_port #(.ADDR_WIDTH(14), .REG_RESET(RST_REGS)) dut (
    .phi(phi), .reset(reset), .cpu_mode(cpu_mode), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .vdp_regs(vdp_regs),
    .frame_tick(frame_tick), .spr_coll(spr_coll), .spr_5s(spr_5s),
    .spr_5th_num(spr_5th_num), .irq(irq), .vram(vram_bus)
  );

  always #5 phi = ~phi;

  typedef struct { logic [13:0] a; logic we; logic [7:0] d; } xact_t;

  int checks = 0, errors = 0;
  bit chk_on = 1'b0;

  // Model state
  logic [7:0]  m_regs [8];
  logic [13:0] m_addr;
  logic [7:0]  m_latch, m_rbuf;
  logic        m_flag, m_f, m_5s, m_c;
  logic [4:0]  m_num;
  logic [7:0]  mem [16384];
  xact_t       expq[$];
  xact_t       wlog[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] m_regs_flat();
    logic [63:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i*8 +: 8] = m_regs[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int unsigned i = 0; i < 8; i++) m_regs[i] = RST_REGS[i*8 +: 8];
    m_addr = '0; m_latch = '0; m_rbuf = '0; m_flag = 1'b0;
    m_f = 1'b0; m_5s = 1'b0; m_c = 1'b0; m_num = '0;
  endtask

  task automatic push(input logic [13:0] a, input logic we, input logic [7:0] d);
    xact_t x;
    x.a = a; x.we = we; x.d = d;
    expq.push_back(x);
  endtask

  // Per-cycle comparison of register file and irq against the model
  always @(negedge phi) begin
    if (chk_on) begin
      chk("vdp_regs", vdp_regs, m_regs_flat());
      chk("irq", {63'd0, irq}, {63'd0, m_f & m_regs[1][5]});
    end
  end

  // VRAM responder: acks after a short latency, checks request vs model order
  int lat = 0;
  always @(negedge phi) begin
    if (vram_bus.vram_ack) begin
      vram_bus.vram_ack = 1'b0;
      lat = 0;
    end else if (vram_bus.vram_req) begin
      if (lat < 2) lat++;
      else begin
        if (expq.size() == 0) begin
          chk("vram_unexpected_req", {50'd0, vram_bus.vram_addr}, 64'hFFFF_FFFF);
        end else begin
          xact_t x;
          x = expq.pop_front();
          chk("vram_addr", {50'd0, vram_bus.vram_addr}, {50'd0, x.a});
          chk("vram_we", {63'd0, vram_bus.vram_we}, {63'd0, x.we});
          if (x.we) begin
            chk("vram_wdata", {56'd0, vram_bus.vram_wdata}, {56'd0, x.d});
            mem[x.a] = x.d;
          end else begin
            m_rbuf = mem[x.a];
          end
        end
        if (vram_bus.vram_we) begin
          xact_t w;
          w.a = vram_bus.vram_addr; w.we = 1'b1; w.d = vram_bus.vram_wdata;
          wlog.push_back(w);
        end
        vram_bus.vram_rdata = mem[vram_bus.vram_addr];
        vram_bus.vram_ack = 1'b1;
      end
    end else lat = 0;
  end

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge phi);
      done = (expq.size() == 0) && !vram_bus.vram_req && !vram_bus.vram_ack;
    end
    if (!done) chk("vram_idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge phi); reset = 1'b1;
    @(posedge phi); #1 model_reset();
    @(negedge phi); reset = 1'b0;
  endtask

  task automatic ctrl_wr(input logic [7:0] b);
    @(negedge phi); cpu_mode = 1'b1; cpu_din = b; cpu_wr = 1'b1;
    @(posedge phi); #1;
    if (!m_flag) begin
      m_latch = b; m_flag = 1'b1;
    end else begin
      m_flag = 1'b0;
      if (b[7]) m_regs[b[2:0]] = m_latch;
      else begin
        m_addr = {b[5:0], m_latch};
        if (!b[6]) begin push(m_addr, 1'b0, 8'h00); m_addr = m_addr + 14'd1; end
      end
    end
    @(negedge phi); @(negedge phi); cpu_wr = 1'b0;
    @(negedge phi);
  endtask

  task automatic data_wr(input logic [7:0] b, input logic also_rd);
    @(negedge phi); cpu_mode = 1'b0; cpu_din = b; cpu_wr = 1'b1; cpu_rd = also_rd;
    @(posedge phi); #1;
    push(m_addr, 1'b1, b); m_rbuf = b; m_addr = m_addr + 14'd1; m_flag = 1'b0;
    @(negedge phi); @(negedge phi); cpu_wr = 1'b0; cpu_rd = 1'b0;
    @(negedge phi);
  endtask

  task automatic data_rd(input string nm, input logic [7:0] lit);
    logic [7:0] e;
    wait_idle();
    @(negedge phi); cpu_mode = 1'b0; cpu_rd = 1'b1;
    @(posedge phi); #1 e = m_rbuf;
    @(negedge phi);
    chk({nm, "_model"}, {56'd0, cpu_dout}, {56'd0, e});
    chk(nm, {56'd0, cpu_dout}, {56'd0, lit});
    cpu_rd = 1'b0;
    @(posedge phi); #1;
    push(m_addr, 1'b0, 8'h00); m_addr = m_addr + 14'd1; m_flag = 1'b0;
    @(negedge phi);
    chk({nm, "_hold"}, {56'd0, cpu_dout}, {56'd0, e});
  endtask

  task automatic stat_rd(input string nm, input logic [7:0] lit, input logic set_f);
    logic [7:0] e;
    @(negedge phi); cpu_mode = 1'b1; cpu_rd = 1'b1;
    @(posedge phi); #1 e = {m_f, m_5s, m_c, m_num};
    @(negedge phi);
    chk({nm, "_model"}, {56'd0, cpu_dout}, {56'd0, e});
    chk(nm, {56'd0, cpu_dout}, {56'd0, lit});
    cpu_rd = 1'b0; frame_tick = set_f;
    @(posedge phi); #1;
    m_f = set_f; m_5s = 1'b0; m_c = 1'b0; m_flag = 1'b0;
    @(negedge phi); frame_tick = 1'b0;
  endtask

  task automatic pulse(input logic f, input logic c, input logic s, input logic [4:0] n);
    @(negedge phi); frame_tick = f; spr_coll = c; spr_5s = s; spr_5th_num = n;
    @(posedge phi); #1;
    m_f = m_f | f; m_c = m_c | c; m_5s = m_5s | s;
    if (s) m_num = n;
    @(negedge phi); frame_tick = 1'b0; spr_coll = 1'b0; spr_5s = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vram_bus.vram_ack = 1'b0;
    vram_bus.vram_rdata = '0;
    for (int unsigned i = 0; i < 16384; i++) mem[i] = '0;
    model_reset();
    do_reset();
    chk_on = 1'b1;
    @(negedge phi);
    chk("rst_regs", vdp_regs, 64'hC300_0000_0000_00F0);
    chk("rst_dout", {56'd0, cpu_dout}, 64'd0);
    chk("rst_req", {63'd0, vram_bus.vram_req}, 64'd0);

    // Register write
    ctrl_wr(8'h60); ctrl_wr(8'h81);
    chk("reg1_60", {56'd0, vdp_regs[15:8]}, 64'h60);

    // Write set-up and two data writes (second may queue as pending)
    ctrl_wr(8'h00); ctrl_wr(8'h48);
    data_wr(8'hAA, 1'b0); data_wr(8'h55, 1'b0);
    wait_idle();
    chk("wlog_n2", wlog.size(), 2);
    chk("wr0", {42'd0, wlog[0].a, wlog[0].d}, {42'd0, 14'h0800, 8'hAA});
    chk("wr1", {42'd0, wlog[1].a, wlog[1].d}, {42'd0, 14'h0801, 8'h55});

    // Read set-up with read-ahead
    mem[14'h0800] = 8'h3C;
    ctrl_wr(8'h00); ctrl_wr(8'h08);
    data_rd("rd_3c", 8'h3C);
    data_rd("rd_55", 8'h55);
    wait_idle();

    // Frame interrupt and status reads
    ctrl_wr(8'h20); ctrl_wr(8'h81);
    pulse(1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge phi);
    chk("irq_set", {63'd0, irq}, 64'd1);
    stat_rd("stat_f", 8'h80, 1'b0);
    chk("irq_clr", {63'd0, irq}, 64'd0);
    stat_rd("stat_empty", 8'h00, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, 5'h15);
    stat_rd("stat_5s_c", 8'h75, 1'b0);
    stat_rd("stat_num_kept", 8'h15, 1'b0);
    // Set coincident with clear keeps F
    pulse(1'b1, 1'b0, 1'b0, 5'd0);
    stat_rd("stat_f2", 8'h95, 1'b1);
    chk("irq_set_wins", {63'd0, irq}, 64'd1);
    stat_rd("stat_f3", 8'h95, 1'b0);

    // Address wrap at top of VRAM
    ctrl_wr(8'hFF); ctrl_wr(8'h7F);
    data_wr(8'h11, 1'b0); data_wr(8'h11, 1'b0);
    wait_idle();
    chk("wr_top", {42'd0, wlog[2].a, wlog[2].d}, {42'd0, 14'h3FFF, 8'h11});
    chk("wr_wrap", {42'd0, wlog[3].a, wlog[3].d}, {42'd0, 14'h0000, 8'h11});

    // Write and read strobes together: write only
    data_wr(8'h77, 1'b1);
    wait_idle();
    chk("wr_both", {42'd0, wlog[4].a, wlog[4].d}, {42'd0, 14'h0001, 8'h77});

    // Reset clears the half-written control pair
    ctrl_wr(8'h12);
    do_reset();
    ctrl_wr(8'h34);
    chk("regs_after_rst", vdp_regs, 64'hC300_0000_0000_00F0);
    ctrl_wr(8'h87);
    chk("reg7_34", {56'd0, vdp_regs[63:56]}, 64'h34);

    wait_idle();
    chk("expq_empty", expq.size(), 0);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
